// File: rtl/alu_mc_if.sv
// Request/response bundle between the decode stage, alu_mc and writeback.
interface alu_mc_if #(
  parameter int unsigned WIDTH = 32
);
  logic             valid_i;
  logic             ready_o;
  logic [WIDTH-1:0] src1_i;
  logic [WIDTH-1:0] src2_i;
  logic [3:0]       ctrl_i;
  logic             valid_o;
  logic             ready_i;
  logic [WIDTH-1:0] result_o;
  logic             zero_o;
  logic             overflow_o;

  modport master (
    output valid_i, src1_i, src2_i, ctrl_i, ready_i,
    input  ready_o, valid_o, result_o, zero_o, overflow_o
  );

  modport slave (
    input  valid_i, src1_i, src2_i, ctrl_i, ready_i,
    output ready_o, valid_o, result_o, zero_o, overflow_o
  );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith/shift ops plus iterative
// shift-add MUL and restoring DIVU/REMU, with valid/ready on both sides.
module alu_mc #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned MULDIV_EN = 1
) (
  input logic    clk_i,
  input logic    rst_i,
  alu_mc_if.slave bus
);
  localparam int unsigned SHW = $clog2(WIDTH);
  localparam logic [3:0] OP_MUL  = 4'd3;
  localparam logic [3:0] OP_DIVU = 4'd4;
  localparam logic [3:0] OP_REMU = 4'd5;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q, state_d;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q, acc_q;
  logic [SHW-1:0]   cnt_q;
  logic             load_single, load_iter, step, finish, retire;
  logic             is_iter;

  logic [WIDTH-1:0] single_res, sum, diff;
  logic             single_ov;
  logic [SHW-1:0]   shamt;

  logic [WIDTH-1:0] mul_acc_nxt, div_rem_nxt, div_quo_nxt, iter_res;
  logic [WIDTH:0]   rem_sh;
  logic             rem_ge;

  assign is_iter = (MULDIV_EN != 0) &&
                   (bus.ctrl_i == OP_MUL || bus.ctrl_i == OP_DIVU || bus.ctrl_i == OP_REMU);

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state and datapath strobes
  always_comb begin
    state_d     = state_q;
    load_single = 1'b0;
    load_iter   = 1'b0;
    step        = 1'b0;
    finish      = 1'b0;
    retire      = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.valid_i) begin
          if (is_iter) begin
            load_iter = 1'b1;
            state_d   = BUSY;
          end else begin
            load_single = 1'b1;
            state_d     = DONE;
          end
        end
      end
      BUSY: begin
        step = 1'b1;
        if (cnt_q == '0) begin
          finish  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.ready_i) begin
          retire  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Single-cycle ops, computed straight from the request being accepted
  always_comb begin
    single_res = '0;
    single_ov  = 1'b0;
    shamt      = bus.src2_i[SHW-1:0];
    sum        = bus.src1_i + bus.src2_i;
    diff       = bus.src1_i - bus.src2_i;
    case (bus.ctrl_i)
      4'd0:  single_res = bus.src1_i & bus.src2_i;
      4'd1:  single_res = bus.src1_i | bus.src2_i;
      4'd2: begin
        single_res = sum;
        single_ov  = (bus.src1_i[WIDTH-1] == bus.src2_i[WIDTH-1]) &&
                     (sum[WIDTH-1] != bus.src1_i[WIDTH-1]);
      end
      4'd6: begin
        single_res = diff;
        single_ov  = (bus.src1_i[WIDTH-1] != bus.src2_i[WIDTH-1]) &&
                     (diff[WIDTH-1] != bus.src1_i[WIDTH-1]);
      end
      4'd7:  single_res = {{(WIDTH-1){1'b0}}, (bus.src1_i < bus.src2_i)};
      4'd8:  single_res = bus.src1_i << shamt;
      4'd9:  single_res = bus.src1_i >> shamt;
      4'd10: single_res = $unsigned($signed(bus.src1_i) >>> shamt);
      4'd12: single_res = ~(bus.src1_i | bus.src2_i);
      4'd13: single_res = {{(WIDTH-1){1'b0}}, ($signed(bus.src1_i) < $signed(bus.src2_i))};
      4'd15: single_res = bus.src1_i ^ bus.src2_i;
      default: single_res = '0;
    endcase
  end

  // One iteration: MUL adds the shifted multiplicand; DIV shifts in a dividend bit
  // (quotient bits share a_q with the remaining dividend bits).
  always_comb begin
    mul_acc_nxt = acc_q + (b_q[0] ? a_q : '0);
    rem_sh      = {acc_q, a_q[WIDTH-1]};
    rem_ge      = rem_sh >= {1'b0, b_q};
    div_rem_nxt = rem_ge ? WIDTH'(rem_sh - {1'b0, b_q}) : rem_sh[WIDTH-1:0];
    div_quo_nxt = {a_q[WIDTH-2:0], rem_ge};
    case (op_q)
      OP_MUL:  iter_res = mul_acc_nxt;
      OP_DIVU: iter_res = div_quo_nxt;
      default: iter_res = div_rem_nxt;
    endcase
  end

  // Operand/iteration registers and registered outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      op_q           <= '0;
      a_q            <= '0;
      b_q            <= '0;
      acc_q          <= '0;
      cnt_q          <= '0;
      bus.valid_o    <= 1'b0;
      bus.ready_o    <= 1'b1;
      bus.result_o   <= '0;
      bus.zero_o     <= 1'b0;
      bus.overflow_o <= 1'b0;
    end else begin
      bus.ready_o <= (state_d == IDLE);
      if (load_iter) begin
        op_q  <= bus.ctrl_i;
        a_q   <= bus.src1_i;
        b_q   <= bus.src2_i;
        acc_q <= '0;
        cnt_q <= SHW'(WIDTH - 1);
      end
      if (load_single) begin
        bus.result_o   <= single_res;
        bus.zero_o     <= (single_res == '0);
        bus.overflow_o <= single_ov;
        bus.valid_o    <= 1'b1;
      end
      if (step) begin
        cnt_q <= cnt_q - SHW'(1);
        if (op_q == OP_MUL) begin
          acc_q <= mul_acc_nxt;
          a_q   <= {a_q[WIDTH-2:0], 1'b0};
          b_q   <= {1'b0, b_q[WIDTH-1:1]};
        end else begin
          acc_q <= div_rem_nxt;
          a_q   <= div_quo_nxt;
        end
      end
      if (finish) begin
        bus.result_o   <= iter_res;
        bus.zero_o     <= (iter_res == '0);
        bus.overflow_o <= 1'b0;
        bus.valid_o    <= 1'b1;
      end
      if (retire) bus.valid_o <= 1'b0;
    end
  end
endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc: 32-bit unit, 32-bit unit without MUL/DIV, 8-bit unit.
module tb_alu_mc;
  logic clk = 1'b0;
  logic rst;
  int   total  = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  alu_mc_if #(.WIDTH(32)) b32 ();
  alu_mc_if #(.WIDTH(32)) b0 ();
  alu_mc_if #(.WIDTH(8))  b8 ();

  assign b0.valid_i = b32.valid_i;
  assign b0.src1_i  = b32.src1_i;
  assign b0.src2_i  = b32.src2_i;
  assign b0.ctrl_i  = b32.ctrl_i;
  assign b0.ready_i = b32.ready_i;

  alu_mc #(.WIDTH(32), .MULDIV_EN(1)) u32 (.clk_i(clk), .rst_i(rst), .bus(b32.slave));
  alu_mc #(.WIDTH(32), .MULDIV_EN(0)) u0  (.clk_i(clk), .rst_i(rst), .bus(b0.slave));
  alu_mc #(.WIDTH(8),  .MULDIV_EN(1)) u8  (.clk_i(clk), .rst_i(rst), .bus(b8.slave));

  task automatic chk(string tag, string what, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s.%s: observed %h expected %h", tag, what, obs, exp);
  endtask

  // Issue one op on the 32-bit units; hold ready_i low for 'hold' cycles once valid_o rises.
  task automatic op32(string tag, logic [3:0] op, logic [31:0] a, logic [31:0] b,
                      logic [31:0] exp, logic exp_ov, int lat, int hold);
    int n;
    @(negedge clk);
    b32.ctrl_i  = op;
    b32.src1_i  = a;
    b32.src2_i  = b;
    b32.valid_i = 1'b1;
    b32.ready_i = (hold == 0);
    chk(tag, "ready_before", 32'(b32.ready_o), 32'd1);
    @(negedge clk);
    n = 1;
    b32.valid_i = 1'b0;
    b32.src1_i  = $urandom;
    b32.src2_i  = $urandom;
    b32.ctrl_i  = 4'($urandom);
    chk(tag, "nomd_valid", 32'(b0.valid_o), 32'd1);
    chk(tag, "nomd_result", b0.result_o, (op == 4'd3 || op == 4'd4 || op == 4'd5) ? 32'd0 : exp);
    while (!b32.valid_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(tag, "latency", 32'(n), 32'(lat));
    chk(tag, "result", b32.result_o, exp);
    chk(tag, "zero", 32'(b32.zero_o), 32'(exp == 32'd0));
    chk(tag, "overflow", 32'(b32.overflow_o), 32'(exp_ov));
    for (int i = 0; i < hold; i++) begin
      b32.valid_i = ~b32.valid_i;
      b32.src1_i  = $urandom;
      b32.src2_i  = $urandom;
      b32.ctrl_i  = 4'($urandom);
      @(negedge clk);
      chk(tag, "hold_valid", 32'(b32.valid_o), 32'd1);
      chk(tag, "hold_result", b32.result_o, exp);
      chk(tag, "hold_ready", 32'(b32.ready_o), 32'd0);
    end
    b32.valid_i = 1'b0;
    b32.ready_i = 1'b1;
    @(negedge clk);
    chk(tag, "valid_drop", 32'(b32.valid_o), 32'd0);
    chk(tag, "ready_back", 32'(b32.ready_o), 32'd1);
  endtask

  task automatic op8(string tag, logic [3:0] op, logic [7:0] a, logic [7:0] b,
                     logic [7:0] exp, logic exp_ov, int lat);
    int n;
    @(negedge clk);
    b8.ctrl_i  = op;
    b8.src1_i  = a;
    b8.src2_i  = b;
    b8.valid_i = 1'b1;
    b8.ready_i = 1'b1;
    @(negedge clk);
    n = 1;
    b8.valid_i = 1'b0;
    b8.src1_i  = 8'($urandom);
    b8.src2_i  = 8'($urandom);
    while (!b8.valid_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(tag, "latency", 32'(n), 32'(lat));
    chk(tag, "result", 32'(b8.result_o), 32'(exp));
    chk(tag, "zero", 32'(b8.zero_o), 32'(exp == 8'd0));
    chk(tag, "overflow", 32'(b8.overflow_o), 32'(exp_ov));
    @(negedge clk);
    chk(tag, "valid_drop", 32'(b8.valid_o), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    b32.valid_i = 1'b0; b32.ready_i = 1'b1; b32.src1_i = '0; b32.src2_i = '0; b32.ctrl_i = '0;
    b8.valid_i  = 1'b0; b8.ready_i  = 1'b1; b8.src1_i  = '0; b8.src2_i  = '0; b8.ctrl_i  = '0;
    repeat (3) @(negedge clk);
    chk("reset", "valid", 32'(b32.valid_o), 32'd0);
    chk("reset", "result", b32.result_o, 32'd0);
    chk("reset", "zero", 32'(b32.zero_o), 32'd0);
    chk("reset", "overflow", 32'(b32.overflow_o), 32'd0);
    chk("reset", "ready", 32'(b32.ready_o), 32'd1);
    chk("reset", "ready8", 32'(b8.ready_o), 32'd1);
    rst = 1'b0;

    op32("add_ovf",  4'd2,  32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 1'b1, 1, 0);
    op32("sub_zero", 4'd6,  32'd5,         32'd5,         32'h0,         1'b0, 1, 0);
    op32("sub_ovf",  4'd6,  32'h8000_0000, 32'h1,         32'h7FFF_FFFF, 1'b1, 1, 0);
    op32("slt",      4'd13, 32'hFFFF_FFFF, 32'h1,         32'h1,         1'b0, 1, 0);
    op32("sltu",     4'd7,  32'hFFFF_FFFF, 32'h1,         32'h0,         1'b0, 1, 0);
    op32("and",      4'd0,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1, 0);
    op32("or",       4'd1,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1'b0, 1, 0);
    op32("nor",      4'd12, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h000F_000F, 1'b0, 1, 0);
    op32("op11",     4'd11, 32'h1234_5678, 32'h9,         32'h0,         1'b0, 1, 0);
    op32("op14",     4'd14, 32'h1234_5678, 32'h9,         32'h0,         1'b0, 1, 0);
    op32("sra",      4'd10, 32'h8000_0000, 32'd31,        32'hFFFF_FFFF, 1'b0, 1, 0);
    op32("sll_mask", 4'd8,  32'h1,         32'd33,        32'h2,         1'b0, 1, 0);
    op32("srl",      4'd9,  32'h8000_0000, 32'd4,         32'h0800_0000, 1'b0, 1, 0);
    op32("mul",      4'd3,  32'h0001_0001, 32'h0001_0001, 32'h0002_0001, 1'b0, 33, 0);
    op32("mul_neg",  4'd3,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1,         1'b0, 33, 0);
    op32("divu",     4'd4,  32'd100,       32'd7,         32'd14,        1'b0, 33, 0);
    op32("remu",     4'd5,  32'd100,       32'd7,         32'd2,         1'b0, 33, 0);
    op32("divu_z",   4'd4,  32'd9,         32'd0,         32'hFFFF_FFFF, 1'b0, 33, 0);
    op32("remu_z",   4'd5,  32'd9,         32'd0,         32'd9,         1'b0, 33, 0);
    op32("xor_hold", 4'd15, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 1'b0, 1, 10);

    // Reset in the middle of a division abandons it
    @(negedge clk);
    b32.ctrl_i = 4'd4; b32.src1_i = 32'd1000; b32.src2_i = 32'd3; b32.valid_i = 1'b1;
    @(negedge clk);
    b32.valid_i = 1'b0;
    repeat (9) @(negedge clk);
    chk("rst_mid", "busy", 32'(b32.ready_o), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid", "valid", 32'(b32.valid_o), 32'd0);
    chk("rst_mid", "result", b32.result_o, 32'd0);
    chk("rst_mid", "ready", 32'(b32.ready_o), 32'd1);
    rst = 1'b0;
    op32("add_after_rst", 4'd2, 32'd2, 32'd3, 32'd5, 1'b0, 1, 0);

    op8("w8_add_ovf", 4'd2,  8'h7F, 8'h01, 8'h80, 1'b1, 1);
    op8("w8_sub",     4'd6,  8'd5,  8'd5,  8'h00, 1'b0, 1);
    op8("w8_slt",     4'd13, 8'hFF, 8'h01, 8'h01, 1'b0, 1);
    op8("w8_sltu",    4'd7,  8'hFF, 8'h01, 8'h00, 1'b0, 1);
    op8("w8_sra",     4'd10, 8'h80, 8'd7,  8'hFF, 1'b0, 1);
    op8("w8_sll",     4'd8,  8'h01, 8'd9,  8'h02, 1'b0, 1);
    op8("w8_mul",     4'd3,  8'h11, 8'h11, 8'h21, 1'b0, 9);
    op8("w8_divu",    4'd4,  8'd100, 8'd7, 8'd14, 1'b0, 9);
    op8("w8_remu",    4'd5,  8'd100, 8'd7, 8'd2,  1'b0, 9);
    op8("w8_divu_z",  4'd4,  8'd9,  8'd0,  8'hFF, 1'b0, 9);
    op8("w8_remu_z",  4'd5,  8'd9,  8'd0,  8'd9,  1'b0, 9);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
